ycr_dmem_sram_resp: RTL and testbench

- Responder (target) end of the core DMEM req/ack/resp protocol; the slave a DMEM router port connects to.
- Accepts byte/halfword/word reads and writes and drives a single-port synchronous SRAM macro (1-cycle read latency, active-low chip/write enables, byte write mask).
- Returns RDY_OK or RDY_ER in the data phase, with optional wait states.
- Supports back-to-back transactions when WAIT_STATES=0.

---
 rtl/ycr_dmem_sram_resp_pkg.sv | 19 +
 rtl/ycr_dmem_sram_resp_if.sv | 24 ++
 rtl/ycr_dmem_lane_align.sv | 49 ++++
 rtl/ycr_dmem_sram_resp.sv | 143 ++++++++++++++
 tb/tb_ycr_dmem_sram_resp.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ycr_dmem_sram_resp_pkg.sv
// Shared DMEM protocol constants for the SRAM responder.
// The encodings match the core's ycr_memif.svh definitions.
package ycr_dmem_sram_resp_pkg;

  localparam int YCR_DMEM_AWIDTH = 32;
  localparam int YCR_DMEM_DWIDTH = 32;

  localparam logic YCR_MEM_CMD_RD = 1'b0;
  localparam logic YCR_MEM_CMD_WR = 1'b1;

  localparam logic [1:0] YCR_MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] YCR_MEM_WIDTH_HWORD = 2'b01;
  localparam logic [1:0] YCR_MEM_WIDTH_WORD  = 2'b10;

  localparam logic [1:0] YCR_MEM_RESP_NOTRDY = 2'b00;
  localparam logic [1:0] YCR_MEM_RESP_RDY_OK = 2'b01;
  localparam logic [1:0] YCR_MEM_RESP_RDY_ER = 2'b10;

endpackage

// File: rtl/ycr_dmem_sram_resp_if.sv
// DMEM req/ack/resp bus between a router port (master) and a target (slave).
interface ycr_dmem_sram_resp_if;
  import ycr_dmem_sram_resp_pkg::*;

  logic                       dmem_req_ack;
  logic                       dmem_req;
  logic                       dmem_cmd;
  logic [1:0]                 dmem_width;
  logic [YCR_DMEM_AWIDTH-1:0] dmem_addr;
  logic [YCR_DMEM_DWIDTH-1:0] dmem_wdata;
  logic [YCR_DMEM_DWIDTH-1:0] dmem_rdata;
  logic [1:0]                 dmem_resp;

  modport master (
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

  modport slave (
    output dmem_req_ack, dmem_rdata, dmem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

endinterface

// File: rtl/ycr_dmem_lane_align.sv
// Byte-lane steering between LSB-justified DMEM data and a 32-bit SRAM word,
// plus the alignment check for a given access width and byte offset.
module ycr_dmem_lane_align
  import ycr_dmem_sram_resp_pkg::*;
(
  input  logic [1:0]                 width,
  input  logic [1:0]                 off,
  input  logic                       cmd,
  input  logic [YCR_DMEM_DWIDTH-1:0] wdata,
  input  logic [31:0]                sram_dout,
  output logic                       err,
  output logic [3:0]                 wmask,
  output logic [31:0]                din,
  output logic [YCR_DMEM_DWIDTH-1:0] rdata_aligned
);

  logic [4:0]  shamt;
  logic [31:0] dout_shifted;
  logic [3:0]  lane_mask;

  assign shamt = {off, 3'b000};

  always_comb begin
    err           = 1'b0;
    lane_mask     = 4'b0000;
    rdata_aligned = '0;
    din           = wdata << shamt;
    dout_shifted  = sram_dout >> shamt;
    case (width)
      YCR_MEM_WIDTH_BYTE: begin
        lane_mask     = 4'b0001 << off;
        rdata_aligned = {24'b0, dout_shifted[7:0]};
      end
      YCR_MEM_WIDTH_HWORD: begin
        err           = off[0];
        lane_mask     = 4'b0011 << off;
        rdata_aligned = {16'b0, dout_shifted[15:0]};
      end
      YCR_MEM_WIDTH_WORD: begin
        err           = |off;
        lane_mask     = 4'b1111;
        rdata_aligned = dout_shifted;
      end
      default: err = 1'b1;
    endcase
    wmask = (cmd == YCR_MEM_CMD_WR && !err) ? lane_mask : 4'b0000;
  end

endmodule

// File: rtl/ycr_dmem_sram_resp.sv
// DMEM target that serves byte/halfword/word accesses from a single-port
// synchronous SRAM (1-cycle read latency), with optional response wait states.
module ycr_dmem_sram_resp
  import ycr_dmem_sram_resp_pkg::*;
#(
  parameter int SRAM_AWIDTH = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ycr_dmem_sram_resp_if.slave    dmem,
  output logic                   sram_csb,
  output logic                   sram_web,
  output logic [3:0]             sram_wmask,
  output logic [SRAM_AWIDTH-1:0] sram_addr,
  output logic [31:0]            sram_din,
  input  logic [31:0]            sram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_e     state_q, state_d;
  logic       err_q, err_d;
  logic       cmd_q, cmd_d;
  logic [1:0] width_q, width_d;
  logic [1:0] off_q, off_d;
  logic [2:0] cnt_q, cnt_d;

  logic                       req_ack;
  logic                       accept;
  logic                       launch;
  logic                       req_err;
  logic [3:0]                 req_wmask;
  logic [31:0]                req_din;
  logic [YCR_DMEM_DWIDTH-1:0] rsp_rdata;

  logic [YCR_DMEM_DWIDTH-1:0] unused_req_rdata;
  logic                       unused_rsp_err;
  logic [3:0]                 unused_rsp_wmask;
  logic [31:0]                unused_rsp_din;
  logic                       unused_addr_hi;

  // Address decode above the SRAM window is the router's job.
  assign unused_addr_hi = ^dmem.dmem_addr[YCR_DMEM_AWIDTH-1:SRAM_AWIDTH+2];

  ycr_dmem_lane_align u_req_align (
    .width         (dmem.dmem_width),
    .off           (dmem.dmem_addr[1:0]),
    .cmd           (dmem.dmem_cmd),
    .wdata         (dmem.dmem_wdata),
    .sram_dout     (32'b0),
    .err           (req_err),
    .wmask         (req_wmask),
    .din           (req_din),
    .rdata_aligned (unused_req_rdata)
  );

  ycr_dmem_lane_align u_rsp_align (
    .width         (width_q),
    .off           (off_q),
    .cmd           (cmd_q),
    .wdata         ('0),
    .sram_dout     (sram_dout),
    .err           (unused_rsp_err),
    .wmask         (unused_rsp_wmask),
    .din           (unused_rsp_din),
    .rdata_aligned (rsp_rdata)
  );

  // An error response blocks acceptance so the router can return to its address phase.
  assign req_ack = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_RESP) & ~err_q));
  assign accept  = dmem.dmem_req & req_ack;
  assign launch  = accept & ~req_err;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    width_d = width_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      err_d   = req_err;
      cmd_d   = dmem.dmem_cmd;
      width_d = dmem.dmem_width;
      off_d   = dmem.dmem_addr[1:0];
      if (req_err || WAIT_STATES == 0) begin
        state_d = ST_RESP;
        cnt_d   = 3'd0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = WS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      cmd_q   <= YCR_MEM_CMD_RD;
      width_q <= YCR_MEM_WIDTH_WORD;
      off_q   <= 2'b00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    dmem.dmem_req_ack = req_ack;
    dmem.dmem_resp    = YCR_MEM_RESP_NOTRDY;
    dmem.dmem_rdata   = '0;
    if (rst_n && state_q == ST_RESP) begin
      dmem.dmem_resp = err_q ? YCR_MEM_RESP_RDY_ER : YCR_MEM_RESP_RDY_OK;
      if (!err_q && cmd_q == YCR_MEM_CMD_RD) dmem.dmem_rdata = rsp_rdata;
    end
  end

  always_comb begin
    sram_csb   = ~launch;
    sram_web   = launch ? ~dmem.dmem_cmd : 1'b1;
    sram_wmask = launch ? req_wmask : 4'b0000;
    sram_addr  = rst_n ? dmem.dmem_addr[SRAM_AWIDTH+1:2] : '0;
    sram_din   = rst_n ? req_din : 32'b0;
  end

endmodule

// File: tb/tb_ycr_dmem_sram_resp.sv
// Directed bench for ycr_dmem_sram_resp: two DUTs (0 and 3 wait states) share
// stimulus, a byte-level memory model predicts every response cycle.
module tb_ycr_dmem_sram_resp;
  import ycr_dmem_sram_resp_pkg::*;

  localparam int AW        = 9;
  localparam int MEM_BYTES = 4 * (2 ** AW);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel   = 1'b0;
  logic        req   = 1'b0;
  logic        cmd   = 1'b0;
  logic [1:0]  width = 2'b00;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        chk_en = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ycr_dmem_sram_resp_if if0 ();
  ycr_dmem_sram_resp_if if1 ();

  assign if0.dmem_req   = req & ~sel;
  assign if0.dmem_cmd   = cmd;
  assign if0.dmem_width = width;
  assign if0.dmem_addr  = addr;
  assign if0.dmem_wdata = wdata;
  assign if1.dmem_req   = req & sel;
  assign if1.dmem_cmd   = cmd;
  assign if1.dmem_width = width;
  assign if1.dmem_addr  = addr;
  assign if1.dmem_wdata = wdata;

  logic          csb0, web0, csb1, web1;
  logic [3:0]    wmask0, wmask1;
  logic [AW-1:0] saddr0, saddr1;
  logic [31:0]   din0, din1;
  logic [31:0]   dout0 = 32'h0;
  logic [31:0]   dout1 = 32'h0;
  logic [31:0]   mem0 [0:(2**AW)-1];
  logic [31:0]   mem1 [0:(2**AW)-1];

  ycr_dmem_sram_resp #(.SRAM_AWIDTH(AW), .WAIT_STATES(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem       (if0.slave),
    .sram_csb   (csb0),
    .sram_web   (web0),
    .sram_wmask (wmask0),
    .sram_addr  (saddr0),
    .sram_din   (din0),
    .sram_dout  (dout0)
  );

  ycr_dmem_sram_resp #(.SRAM_AWIDTH(AW), .WAIT_STATES(3)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem       (if1.slave),
    .sram_csb   (csb1),
    .sram_web   (web1),
    .sram_wmask (wmask1),
    .sram_addr  (saddr1),
    .sram_din   (din1),
    .sram_dout  (dout1)
  );

  // Single-port synchronous SRAM macros with byte write mask.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) mem0[saddr0][8*i +: 8] <= din0[8*i +: 8];
      end else begin
        dout0 <= mem0[saddr0];
      end
    end
  end

  always @(posedge clk) begin
    if (!csb1) begin
      if (!web1) begin
        for (int i = 0; i < 4; i++)
          if (wmask1[i]) mem1[saddr1][8*i +: 8] <= din1[8*i +: 8];
      end else begin
        dout1 <= mem1[saddr1];
      end
    end
  end

  logic          ack_s, csb_s, web_s;
  logic [1:0]    resp_s;
  logic [31:0]   rdata_s, din_s;
  logic [3:0]    wmask_s;
  logic [AW-1:0] saddr_s;

  assign ack_s   = sel ? if1.dmem_req_ack : if0.dmem_req_ack;
  assign resp_s  = sel ? if1.dmem_resp : if0.dmem_resp;
  assign rdata_s = sel ? if1.dmem_rdata : if0.dmem_rdata;
  assign csb_s   = sel ? csb1 : csb0;
  assign web_s   = sel ? web1 : web0;
  assign wmask_s = sel ? wmask1 : wmask0;
  assign din_s   = sel ? din1 : din0;
  assign saddr_s = sel ? saddr1 : saddr0;

  // Behavioural model: byte memory plus a queue of expected responses keyed by cycle.
  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cmp_e;
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d, dut %0d)", name, act, expv, cyc, sel);
    end
  endtask

  task automatic modelAccept(input logic c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    logic e;
    int   nb;
    int   base;
    e    = (w == 2'b11) || (w == YCR_MEM_WIDTH_HWORD && a[0]) ||
           (w == YCR_MEM_WIDTH_WORD && a[1:0] != 2'b00);
    nb   = (w == YCR_MEM_WIDTH_BYTE) ? 1 : (w == YCR_MEM_WIDTH_HWORD) ? 2 : 4;
    base = int'(a[AW+1:0]);
    x.due   = cyc + 1 + (e ? 0 : (sel ? 3 : 0));
    x.resp  = e ? YCR_MEM_RESP_RDY_ER : YCR_MEM_RESP_RDY_OK;
    x.rdata = 32'h0;
    if (!e) begin
      for (int i = 0; i < nb; i++) begin
        if (c == YCR_MEM_CMD_WR) ref_mem[base + i] = d[8*i +: 8];
        else x.rdata[8*i +: 8] = ref_mem[base + i];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus(input logic c, input logic [1:0] w, input logic [31:0] a,
                               input logic [31:0] d, input logic exp_ack);
    @(negedge clk);
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    #1;
    checkOutput("ack", 32'(ack_s), 32'(exp_ack));
    if (exp_ack) modelAccept(c, w, a, d);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  // Every cycle either the due response or NOTRDY with zero data must be visible.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cmp_e = exp_q.pop_front();
        checkOutput("model_resp", 32'(resp_s), 32'(cmp_e.resp));
        checkOutput("model_rdata", rdata_s, cmp_e.rdata);
      end else begin
        checkOutput("idle_resp", 32'(resp_s), 32'(YCR_MEM_RESP_NOTRDY));
        checkOutput("idle_rdata", rdata_s, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    req = 1'b1; cmd = YCR_MEM_CMD_WR; width = YCR_MEM_WIDTH_WORD;
    addr = 32'h7FC; wdata = 32'hFFFFFFFF;
    @(negedge clk); @(negedge clk); #1;
    checkOutput("rst_ack", 32'(ack_s), 32'h0);
    checkOutput("rst_resp", 32'(resp_s), 32'(YCR_MEM_RESP_NOTRDY));
    checkOutput("rst_rdata", rdata_s, 32'h0);
    checkOutput("rst_csb", 32'(csb_s), 32'h1);
    checkOutput("rst_web", 32'(web_s), 32'h1);
    checkOutput("rst_wmask", 32'(wmask_s), 32'h0);
    checkOutput("rst_addr", 32'(saddr_s), 32'h0);
    checkOutput("rst_din", din_s, 32'h0);

    @(negedge clk);
    rst_n = 1'b1; req = 1'b0; chk_en = 1'b1;
    #1;
    checkOutput("post_rst_ack", 32'(ack_s), 32'h1);

    // Word write then word read, no wait states.
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF, 1'b1);
    checkOutput("wr_csb", 32'(csb_s), 32'h0);
    checkOutput("wr_web", 32'(web_s), 32'h0);
    checkOutput("wr_wmask", 32'(wmask_s), 32'hF);
    checkOutput("wr_din", din_s, 32'hDEADBEEF);
    checkOutput("wr_addr", 32'(saddr_s), 32'h4);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1);
    checkOutput("rd_web", 32'(web_s), 32'h1);
    checkOutput("rd_wmask", 32'(wmask_s), 32'h0);
    checkOutput("wr_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_OK));
    idleCycle();
    checkOutput("rd_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_OK));
    checkOutput("rd_rdata", rdata_s, 32'hDEADBEEF);

    // Sub-word lanes.
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_BYTE, 32'h13, 32'h5A, 1'b1);
    checkOutput("bwr_wmask", 32'(wmask_s), 32'h8);
    checkOutput("bwr_din", din_s, 32'h5A000000);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_BYTE, 32'h13, 32'h0, 1'b1);
    checkOutput("wrd_after_byte", rdata_s, 32'h5AADBEEF);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_HWORD, 32'h12, 32'h0, 1'b1);
    checkOutput("byte_rd", rdata_s, 32'h0000005A);
    idleCycle();
    checkOutput("hword_rd", rdata_s, 32'h00005AAD);

    // Back-to-back writes then reads with req held high.
    for (int i = 0; i < 4; i++)
      applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_WORD, 32'(4 * i), 32'h0A0B0C00 + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++)
      applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'(4 * i), 32'h0, 1'b1);
    idleCycle();
    checkOutput("b2b_last", rdata_s, 32'h0A0B0C03);
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_HWORD, 32'h2, 32'hCAFE, 1'b1);
    checkOutput("hwr_wmask", 32'(wmask_s), 32'hC);
    checkOutput("hwr_din", din_s, 32'hCAFE0000);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h0, 32'h0, 1'b1);
    idleCycle();
    checkOutput("hwr_merge", rdata_s, 32'hCAFE0C00);

    // Error accepts: misaligned halfword, reserved width, misaligned word write.
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_HWORD, 32'h11, 32'h0, 1'b1);
    checkOutput("err_csb", 32'(csb_s), 32'h1);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b0);
    checkOutput("err_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_ER));
    checkOutput("err_rdata", rdata_s, 32'h0);
    applyStimulus(YCR_MEM_CMD_RD, 2'b11, 32'h10, 32'h0, 1'b1);
    checkOutput("w11_csb", 32'(csb_s), 32'h1);
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_WORD, 32'h14, 32'h99, 1'b0);
    checkOutput("w11_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_ER));
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_WORD, 32'h12, 32'hFFFFFFFF, 1'b1);
    checkOutput("mis_wr_csb", 32'(csb_s), 32'h1);
    checkOutput("mis_wr_wmask", 32'(wmask_s), 32'h0);
    idleCycle();
    idleCycle();
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h10, 32'h0, 1'b1);
    idleCycle();
    checkOutput("untouched", rdata_s, 32'h5AADBEEF);

    // Three wait states.
    idleCycle();
    sel = 1'b1;
    applyStimulus(YCR_MEM_CMD_WR, YCR_MEM_WIDTH_WORD, 32'h20, 32'h12345678, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("ws_wr_ack", 32'(ack_s), 32'h0);
    end
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h20, 32'h0, 1'b1);
    checkOutput("ws_wr_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_OK));
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("ws_rd_ack", 32'(ack_s), 32'h0);
      checkOutput("ws_rd_notrdy", 32'(resp_s), 32'(YCR_MEM_RESP_NOTRDY));
    end
    idleCycle();
    checkOutput("ws_rd_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_OK));
    checkOutput("ws_rd_rdata", rdata_s, 32'h12345678);
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_HWORD, 32'h21, 32'h0, 1'b1);
    idleCycle();
    checkOutput("ws_err_resp", 32'(resp_s), 32'(YCR_MEM_RESP_RDY_ER));

    // Reset in the middle of a wait-state read.
    idleCycle();
    applyStimulus(YCR_MEM_CMD_RD, YCR_MEM_WIDTH_WORD, 32'h20, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("mid_rst_ack", 32'(ack_s), 32'h0);
    checkOutput("mid_rst_resp", 32'(resp_s), 32'(YCR_MEM_RESP_NOTRDY));
    checkOutput("mid_rst_csb", 32'(csb_s), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 1'b0;
    #1;
    checkOutput("rel_ack", 32'(ack_s), 32'h1);
    for (int i = 0; i < 6; i++) idleCycle();

    checkOutput("drain_empty", 32'(exp_q.size()), 32'h0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
